// File: rtl/sram_stream_reader_if.sv
// SRAM read port plus output stream of the SRAM stream reader.
// master = reader side, slave = SRAM model / downstream consumer side.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

interface sram_stream_reader_if #(
    parameter int ADDR_W = `ADDR_WIDTH,
    parameter int DATA_W = `DATA_WIDTH
);
    logic              mem_cs;
    logic              mem_oe;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_W_req;
    logic [DATA_W-1:0] mem_W_data;
    logic [DATA_W-1:0] mem_R_data;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;

    modport master (
        output mem_cs, mem_oe, mem_addr, mem_W_req, mem_W_data, out_valid, out_data,
        input  mem_R_data, out_ready
    );

    modport slave (
        input  mem_cs, mem_oe, mem_addr, mem_W_req, mem_W_data, out_valid, out_data,
        output mem_R_data, out_ready
    );
endinterface

// File: rtl/sram_stream_reader.sv
// Fetches LEN consecutive SRAM words after a start pulse and streams them out through a small FIFO.
// Optional macro SRAM_READER_STRIDE_EN adds a per-issue address stride input.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module sram_stream_reader #(
    parameter int ADDR_W     = `ADDR_WIDTH,
    parameter int DATA_W     = `DATA_WIDTH,
    parameter int LEN_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
`ifdef SRAM_READER_STRIDE_EN
    input  logic [ADDR_W-1:0] stride,
`endif
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    sram_stream_reader_if.master bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t            state_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [ADDR_W-1:0] step;
    logic [LEN_W-1:0]  issue_cnt_reg, issue_cnt_next;
    logic [LEN_W-1:0]  recv_cnt_reg, recv_cnt_next;
    logic              mem_cs_reg, inflight_reg, busy_reg, done_reg;
    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic              push, pop, out_valid, credit_ok;

`ifdef SRAM_READER_STRIDE_EN
    logic [ADDR_W-1:0] stride_reg;
    assign step = stride_reg;
`else
    assign step = ADDR_W'(1);
`endif

    // Read data lands one cycle after issue, so the in-flight flag doubles as the FIFO push.
    assign push           = inflight_reg;
    assign out_valid      = (count_reg != '0);
    assign pop            = out_valid & bus.out_ready;
    assign count_next     = count_reg + CNT_W'(push) - CNT_W'(pop);
    assign issue_cnt_next = issue_cnt_reg - LEN_W'(mem_cs_reg);
    assign recv_cnt_next  = recv_cnt_reg - LEN_W'(pop);

    // Next-cycle issue needs room for the occupied entries, this cycle's read, and the new one.
    assign credit_ok = ((CNT_W+1)'(count_next) + (CNT_W+1)'(mem_cs_reg)) < DEPTH_C;

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_reg] <= bus.mem_R_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            issue_cnt_reg <= '0;
            recv_cnt_reg  <= '0;
            mem_cs_reg    <= 1'b0;
            inflight_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
`ifdef SRAM_READER_STRIDE_EN
            stride_reg    <= '0;
`endif
        end else begin
            done_reg     <= 1'b0;
            inflight_reg <= mem_cs_reg;
            count_reg    <= count_next;
            recv_cnt_reg <= recv_cnt_next;
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);

            case (state_reg)
                IDLE: begin
                    if (start) begin
                        addr_reg      <= base_addr;
                        issue_cnt_reg <= length;
                        recv_cnt_reg  <= length;
`ifdef SRAM_READER_STRIDE_EN
                        stride_reg    <= stride;
`endif
                        if (length == '0) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg  <= READ;
                            busy_reg   <= 1'b1;
                            mem_cs_reg <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (mem_cs_reg) addr_reg <= addr_reg + step;
                    issue_cnt_reg <= issue_cnt_next;
                    if (issue_cnt_next == '0) begin
                        state_reg  <= DRAIN;
                        mem_cs_reg <= 1'b0;
                    end else begin
                        mem_cs_reg <= credit_ok;
                    end
                end
                DRAIN: begin
                    if (recv_cnt_next == '0) begin
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_cs     = mem_cs_reg;
    assign bus.mem_oe     = mem_cs_reg;
    assign bus.mem_addr   = addr_reg;
    assign bus.mem_W_req  = 1'b0;
    assign bus.mem_W_data = '0;
    assign bus.out_valid  = out_valid;
    assign bus.out_data   = out_valid ? fifo_mem[rd_ptr_reg] : '0;
    assign busy           = busy_reg;
    assign done           = done_reg;
endmodule

// File: tb/tb_sram_stream_reader.sv
// Self-checking bench for sram_stream_reader: randomized SRAM contents and backpressure,
// expectations from an address/data sequence model of each transfer.
`timescale 1ns/1ps
module tb_sram_stream_reader;
    localparam int AW = 8, DW = 16, LW = 16, DEPTH = 4;
`ifdef SRAM_READER_STRIDE_EN
    localparam bit STRIDE_EN = 1'b1;
`else
    localparam bit STRIDE_EN = 1'b0;
`endif

    logic          clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [AW-1:0] base_addr = '0, stride = '0;
    logic [LW-1:0] length = '0;
    logic          busy, done;

    sram_stream_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    sram_stream_reader #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
`ifdef SRAM_READER_STRIDE_EN
        .stride(stride),
`endif
        .length(length), .busy(busy), .done(done), .bus(bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: synchronous read, data one cycle after cs&oe
    logic [DW-1:0] sram [2**AW];
    always @(posedge clk) if (bus.mem_cs && bus.mem_oe) bus.mem_R_data <= sram[bus.mem_addr];

    // Monitor, sampled mid-cycle
    logic [AW-1:0] issue_q[$];
    int            issue_cyc_q[$];
    logic [DW-1:0] hs_q[$];
    int            hs_cyc_q[$];
    int            done_q[$];
    int            first_valid = -1, busy_at_done = 0, stall_change = 0;
    bit            busy_seen = 0, prev_stall = 0;
    logic [DW-1:0] prev_data = '0;

    always @(negedge clk) begin
        if (bus.mem_cs && bus.mem_oe) begin
            issue_q.push_back(bus.mem_addr);
            issue_cyc_q.push_back(cyc);
        end
        if (bus.out_valid && first_valid < 0) first_valid = cyc;
        if (bus.out_valid && bus.out_ready) begin
            hs_q.push_back(bus.out_data);
            hs_cyc_q.push_back(cyc);
        end
        if (done) begin
            done_q.push_back(cyc);
            if (busy) busy_at_done++;
        end
        if (busy) busy_seen = 1'b1;
        if (prev_stall && (!bus.out_valid || bus.out_data !== prev_data)) stall_change++;
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_data  = bus.out_data;
    end

    int n_tests = 0, n_fail = 0;

    // Reference: i-th word of a transfer comes from base + i*step modulo 2^AW
    function automatic logic [AW-1:0] model_addr(input logic [AW-1:0] b, input logic [AW-1:0] st, input int i);
        int step_i;
        step_i = STRIDE_EN ? int'(st) : 1;
        return AW'((int'(b) + i * step_i) % (2**AW));
    endfunction

    task automatic clear_mon();
        issue_q.delete(); issue_cyc_q.delete(); hs_q.delete(); hs_cyc_q.delete(); done_q.delete();
        first_valid = -1; busy_at_done = 0; stall_change = 0; busy_seen = 1'b0;
    endtask

    // mode: 0 ready always high, 1 random ready, 2 ready low for ten cycles after start
    task automatic run_xfer(input logic [AW-1:0] b, input int len, input logic [AW-1:0] st, input int mode,
                            input int restart_at, input bit start_in_done, output int s_cyc, output bit ok);
        clear_mon();
        @(posedge clk); #1;
        base_addr = b; length = LW'(len); stride = st; start = 1'b1; s_cyc = cyc;
        bus.out_ready = (mode == 1) ? 1'($urandom_range(1)) : (mode == 0);
        @(posedge clk); #1;
        ok = 1'b0;
        for (int k = 1; k < 3000; k++) begin
            start = 1'b0;
            if (k == restart_at || (start_in_done && done)) begin
                start = 1'b1; base_addr = ~b; length = LW'(len + 3);
            end
            case (mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = 1'($urandom_range(1));
                default: bus.out_ready = (cyc > s_cyc + 10);
            endcase
            @(posedge clk); #1;
            if (done_q.size() != 0) begin ok = 1'b1; break; end
        end
        start = 1'b0; bus.out_ready = 1'b1;
        $display("[TB] xfer base=%h len=%0d mode=%0d issued=%0d words=%0d done_at=%0d",
                 b, len, mode, issue_q.size(), hs_q.size(), ok ? done_q[0] - s_cyc : -1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.out_ready = 1'b1;
        idle(3);
        n_tests++; if (busy !== 1'b0)          begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++; if (done !== 1'b0)          begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_tests++; if (bus.mem_cs !== 1'b0)    begin n_fail++; $display("FAIL reset_mem_cs: got %b want 0", bus.mem_cs); end
        n_tests++; if (bus.mem_oe !== 1'b0)    begin n_fail++; $display("FAIL reset_mem_oe: got %b want 0", bus.mem_oe); end
        n_tests++; if (bus.mem_addr !== '0)    begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", bus.mem_addr); end
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        n_tests++; if (bus.out_data !== '0)    begin n_fail++; $display("FAIL reset_out_data: got %h want 0", bus.out_data); end
        n_tests++; if (bus.mem_W_req !== 1'b0 || bus.mem_W_data !== '0)
            begin n_fail++; $display("FAIL reset_write_port: got req=%b data=%h want 0/0", bus.mem_W_req, bus.mem_W_data); end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_basic();
        int s; bit ok;
        run_xfer(8'h10, 4, 8'd1, 0, -1, 1'b0, s, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL basic_timeout: done not seen, required within budget"); end
        n_tests++; if (issue_q.size() != 4) begin n_fail++; $display("FAIL basic_issues: got %0d want 4", issue_q.size()); end
        n_tests++; if (hs_q.size() != 4) begin n_fail++; $display("FAIL basic_words: got %0d want 4", hs_q.size()); end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (i >= hs_q.size() || hs_q[i] !== sram[8'h10 + i]) begin
                n_fail++; $display("FAIL basic_data[%0d]: got %h want %h", i, i < hs_q.size() ? hs_q[i] : 'x, sram[8'h10 + i]);
            end
        end
        // first valid two cycles after the start edge, i.e. three cycles after the start cycle
        n_tests++; if (first_valid != s + 3) begin n_fail++; $display("FAIL basic_first_valid: got cycle +%0d want +3", first_valid - s); end
        n_tests++; if (hs_cyc_q.size() == 4 && hs_cyc_q[3] - hs_cyc_q[0] != 3)
            begin n_fail++; $display("FAIL basic_throughput: got span %0d want 3", hs_cyc_q[3] - hs_cyc_q[0]); end
        n_tests++; if (done_q.size() != 1 || hs_cyc_q.size() == 0 || done_q[0] != hs_cyc_q[hs_cyc_q.size()-1] + 1)
            begin n_fail++; $display("FAIL basic_done_timing: got %0d pulses want 1 pulse one cycle after last handshake", done_q.size()); end
        n_tests++; if (busy_at_done != 0) begin n_fail++; $display("FAIL basic_busy_at_done: got %0d want 0", busy_at_done); end
        idle(3);
    endtask

    task automatic test_backpressure();
        int s, early; bit ok;
        run_xfer(8'h40, 8, 8'd1, 2, -1, 1'b0, s, ok);
        early = 0;
        foreach (issue_cyc_q[i]) if (issue_cyc_q[i] <= s + 10) early++;
        n_tests++; if (!ok) begin n_fail++; $display("FAIL bp_timeout: done not seen, required within budget"); end
        n_tests++; if (early != DEPTH) begin n_fail++; $display("FAIL bp_stall_issues: got %0d want %0d", early, DEPTH); end
        n_tests++; if (issue_q.size() != 8) begin n_fail++; $display("FAIL bp_issues: got %0d want 8", issue_q.size()); end
        n_tests++; if (hs_q.size() != 8) begin n_fail++; $display("FAIL bp_words: got %0d want 8", hs_q.size()); end
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (i >= hs_q.size() || hs_q[i] !== sram[8'h40 + i]) begin
                n_fail++; $display("FAIL bp_data[%0d]: got %h want %h", i, i < hs_q.size() ? hs_q[i] : 'x, sram[8'h40 + i]);
            end
        end
        n_tests++; if (stall_change != 0) begin n_fail++; $display("FAIL bp_stable_data: got %0d changes under stall want 0", stall_change); end
        idle(3);
    endtask

    task automatic test_zero_and_ignored_start();
        int s; bit ok; logic [AW-1:0] b;
        run_xfer(8'h22, 0, 8'd1, 0, -1, 1'b0, s, ok);
        n_tests++; if (!ok || done_q[0] != s + 1) begin n_fail++; $display("FAIL zero_done: got ok=%b at +%0d want done at +1", ok, ok ? done_q[0] - s : -1); end
        n_tests++; if (issue_q.size() != 0) begin n_fail++; $display("FAIL zero_no_access: got %0d reads want 0", issue_q.size()); end
        n_tests++; if (busy_seen) begin n_fail++; $display("FAIL zero_busy: got busy high want low"); end
        idle(2);
        b = AW'($urandom);
        run_xfer(b, 6, 8'd1, 1, 3, 1'b1, s, ok);
        idle(6);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL ign_timeout: done not seen, required within budget"); end
        n_tests++; if (issue_q.size() != 6) begin n_fail++; $display("FAIL ign_issues: got %0d want 6", issue_q.size()); end
        n_tests++; if (done_q.size() != 1) begin n_fail++; $display("FAIL ign_done_count: got %0d want 1", done_q.size()); end
        for (int i = 0; i < 6; i++) begin
            n_tests++;
            if (i >= hs_q.size() || hs_q[i] !== sram[model_addr(b, 8'd1, i)]) begin
                n_fail++; $display("FAIL ign_data[%0d]: got %h want %h", i, i < hs_q.size() ? hs_q[i] : 'x, sram[model_addr(b, 8'd1, i)]);
            end
        end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ign_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_wrap();
        int s; bit ok; logic [AW-1:0] b;
        b = AW'(2**AW - 2);
        run_xfer(b, 4, 8'd1, 0, -1, 1'b0, s, ok);
        n_tests++; if (!ok || issue_q.size() != 4) begin n_fail++; $display("FAIL wrap_issues: got %0d want 4", issue_q.size()); end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (i >= issue_q.size() || issue_q[i] !== AW'((2**AW - 2 + i) % (2**AW))) begin
                n_fail++; $display("FAIL wrap_addr[%0d]: got %h want %h", i, i < issue_q.size() ? issue_q[i] : 'x, AW'((2**AW - 2 + i) % (2**AW)));
            end
            n_tests++;
            if (i >= hs_q.size() || hs_q[i] !== sram[AW'((2**AW - 2 + i) % (2**AW))]) begin
                n_fail++; $display("FAIL wrap_data[%0d]: got %h want %h", i, i < hs_q.size() ? hs_q[i] : 'x, sram[AW'((2**AW - 2 + i) % (2**AW))]);
            end
        end
        idle(2);
    endtask

    task automatic test_reset_mid();
        int s, k; bit ok;
        clear_mon();
        @(posedge clk); #1;
        base_addr = 8'h80; length = LW'(8); start = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (k = 0; k < 40 && hs_q.size() < 2; k++) begin @(posedge clk); #1; end
        n_tests++; if (k >= 40) begin n_fail++; $display("FAIL rstmid_timeout: got %0d words want 2 before reset", hs_q.size()); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        done_q.delete();
        n_tests++; if (busy !== 1'b0)          begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid: got %b want 0", bus.out_valid); end
        n_tests++; if (bus.mem_cs !== 1'b0)    begin n_fail++; $display("FAIL rstmid_mem_cs: got %b want 0", bus.mem_cs); end
        idle(8);
        n_tests++; if (done_q.size() != 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d pulses want 0", done_q.size()); end
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_flushed: got valid %b want 0", bus.out_valid); end
        run_xfer(8'h00, 2, 8'd1, 0, -1, 1'b0, s, ok);
        n_tests++; if (!ok || hs_q.size() != 2) begin n_fail++; $display("FAIL rstmid_rerun_words: got %0d want 2", hs_q.size()); end
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (i >= hs_q.size() || hs_q[i] !== sram[i]) begin
                n_fail++; $display("FAIL rstmid_rerun_data[%0d]: got %h want %h", i, i < hs_q.size() ? hs_q[i] : 'x, sram[i]);
            end
        end
        idle(2);
    endtask

`ifdef SRAM_READER_STRIDE_EN
    task automatic test_stride();
        int s; bit ok;
        run_xfer(8'h00, 4, 8'd3, 0, -1, 1'b0, s, ok);
        n_tests++; if (!ok || issue_q.size() != 4) begin n_fail++; $display("FAIL stride_issues: got %0d want 4", issue_q.size()); end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (i >= issue_q.size() || issue_q[i] !== AW'(3 * i)) begin
                n_fail++; $display("FAIL stride_addr[%0d]: got %h want %h", i, i < issue_q.size() ? issue_q[i] : 'x, AW'(3 * i));
            end
            n_tests++;
            if (i >= hs_q.size() || hs_q[i] !== sram[3 * i]) begin
                n_fail++; $display("FAIL stride_data[%0d]: got %h want %h", i, i < hs_q.size() ? hs_q[i] : 'x, sram[3 * i]);
            end
        end
        idle(2);
    endtask
`endif

    task automatic test_random();
        int s, len; bit ok; logic [AW-1:0] b, st;
        for (int t = 0; t < 8; t++) begin
            b = AW'($urandom); st = AW'($urandom_range(7)); len = $urandom_range(1, 12);
            run_xfer(b, len, st, 1, -1, 1'b0, s, ok);
            n_tests++; if (!ok || issue_q.size() != len || hs_q.size() != len)
                begin n_fail++; $display("FAIL rand%0d_count: got issued=%0d words=%0d want %0d", t, issue_q.size(), hs_q.size(), len); end
            for (int i = 0; i < len && i < hs_q.size() && i < issue_q.size(); i++) begin
                n_tests++;
                if (issue_q[i] !== model_addr(b, st, i) || hs_q[i] !== sram[model_addr(b, st, i)]) begin
                    n_fail++; $display("FAIL rand%0d_word[%0d]: got addr=%h data=%h want addr=%h data=%h",
                                       t, i, issue_q[i], hs_q[i], model_addr(b, st, i), sram[model_addr(b, st, i)]);
                end
            end
            n_tests++; if (done_q.size() != 1 || hs_cyc_q.size() == 0 || done_q[0] != hs_cyc_q[hs_cyc_q.size()-1] + 1)
                begin n_fail++; $display("FAIL rand%0d_done: got %0d pulses want 1 right after last handshake", t, done_q.size()); end
            n_tests++; if (stall_change != 0) begin n_fail++; $display("FAIL rand%0d_stable: got %0d changes want 0", t, stall_change); end
            idle($urandom_range(0, 3));
        end
    endtask

    initial begin
        bus.out_ready = 1'b1;
        foreach (sram[i]) sram[i] = DW'($urandom);
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_and_ignored_start();
        test_wrap();
        test_reset_mid();
`ifdef SRAM_READER_STRIDE_EN
        test_stride();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
